// File: rtl/config_shift_loader_pkg.sv
// Shared fabric configuration definitions: loader state encoding and the
// default word / chain sizes used by the tile-column configuration loader.
package config_shift_loader_pkg;

    localparam int CFG_WORD_W_DEF    = 32;
    localparam int CFG_CHAIN_LEN_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SET   = 3'd3,
        ST_DONE  = 3'd4
    } cfg_state_t;

    // Index width for a counter covering 0..n-1, never narrower than one bit.
    function automatic int cfg_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/config_shift_loader_piso.sv
// Parallel-in serial-out shift register, MSB first. Load wins over shift.
module config_shift_loader_piso #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_sr;

    // Capture a new word or move the current one up by one bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= r_sr << 1;
        end
    end

    assign o_msb = r_sr[W-1];

endmodule

// File: rtl/config_shift_loader.sv
// Tile-column configuration loader: takes host words, serialises them MSB
// first into the column shift chain with a qualifying clock enable, then
// issues a single commit pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no load in progress, waiting for start
// LOAD  | waiting for the next host word, chain clock held off
// SHIFT | one chain bit per cycle on shift_out with cen high
// SET   | whole chain shifted, one-cycle commit pulse on set_out
// DONE  | load complete, waiting for the next start
module config_shift_loader
    import config_shift_loader_pkg::*;
#(
    parameter int WORD_W    = CFG_WORD_W_DEF,
    parameter int CHAIN_LEN = CFG_CHAIN_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_out,
    output logic              cen,
    output logic              set_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = cfg_idx_w(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

    cfg_state_t       r_state;
    cfg_state_t       w_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WB_W-1:0]  r_wbit;
    logic             w_load;
    logic             w_shift;
    logic             w_cnt_clr;
    logic             w_msb;
    logic             w_last_chain;
    logic             w_last_word;

    // The final chain bit takes precedence over the word boundary, so the
    // unused LSBs of a partial last word are simply never shifted out.
    assign w_last_chain = (r_bit_cnt == LAST_BIT);
    assign w_last_word  = (r_wbit == LAST_WBIT);

    config_shift_loader_piso #(
        .W (WORD_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (in_data),
        .o_msb   (w_msb)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Chain bit counter (per load) and bit position within the current word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_wbit    <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_load) begin
                r_wbit <= '0;
            end else if (w_shift) begin
                r_wbit <= r_wbit + 1'b1;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        shift_out = 1'b0;
        cen       = 1'b0;
        set_out   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_cnt_clr = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next    = ST_LOAD;
                    w_cnt_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                cen       = 1'b1;
                shift_out = w_msb;
                w_shift   = 1'b1;
                if (w_last_chain) begin
                    w_next = ST_SET;
                end else if (w_last_word) begin
                    // Accepting here keeps the chain clock running with no bubble.
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end
            end
            ST_SET: begin
                busy    = 1'b1;
                set_out = 1'b1;
                w_next  = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next    = ST_LOAD;
                    w_cnt_clr = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_config_shift_loader.sv
// Bench for config_shift_loader: a 40-bit and a 64-bit chain instance
// driven from a table of load scenarios plus hand-written reset/idle cases.
module tb_config_shift_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_start = 1'b0;
    logic        b_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic a_rdy, a_so, a_cen, a_set, a_busy, a_done;
    logic b_rdy, b_so, b_cen, b_set, b_busy, b_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    config_shift_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (a_start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (a_rdy),
        .shift_out (a_so),
        .cen       (a_cen),
        .set_out   (a_set),
        .busy      (a_busy),
        .done      (a_done)
    );

    config_shift_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (b_start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (b_rdy),
        .shift_out (b_so),
        .cen       (b_cen),
        .set_out   (b_set),
        .busy      (b_busy),
        .done      (b_done)
    );

    typedef struct {
        bit          sel;         // 0: 40-bit chain, 1: 64-bit chain
        int          len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;         // LOAD cycles with in_valid held low before word 1
        bit          mid_start;   // pulse start during the 10th shift cycle
        logic [63:0] exp_stream;
        int          exp_bubble;
    } vec_t;

    vec_t tbl[6];

    // {in_ready, cen, shift_out, set_out, busy, done}
    function automatic logic [5:0] outs(input bit sel);
        if (sel) return {b_rdy, b_cen, b_so, b_set, b_busy, b_done};
        return {a_rdy, a_cen, a_so, a_set, a_busy, a_done};
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) b_start = v;
        else     a_start = v;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_load(input int r);
        vec_t        v;
        logic [5:0]  o;
        logic [63:0] stream;
        int cen_cnt, bubble, set_cnt, set_cyc, done_cyc, last_cen, widx, load_seen;
        bit overlap;
        v = tbl[r];
        stream = '0; cen_cnt = 0; bubble = 0; set_cnt = 0; set_cyc = -1;
        done_cyc = -1; last_cen = -1; widx = 0; load_seen = 0; overlap = 1'b0;

        @(negedge clk);
        set_start(v.sel, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        set_start(v.sel, 1'b0);
        o = outs(v.sel);
        chk($sformatf("row%0d start_busy_done", r), 64'(o[1:0]), 64'b10);

        for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
            o = outs(v.sel);
            if (o[4]) begin
                cen_cnt++;
                stream = {stream[62:0], o[3]};
                if (last_cen >= 0 && cyc - last_cen > 1) bubble += cyc - last_cen - 1;
                last_cen = cyc;
            end
            if (o[2]) begin
                set_cnt++;
                set_cyc = cyc;
                if (o[4]) overlap = 1'b1;
            end
            if (o[0] && set_cyc >= 0) done_cyc = cyc;

            set_start(v.sel, v.mid_start && o[4] && cen_cnt == 10);

            if (widx == 0) begin
                in_valid = 1'b1;
                in_data  = v.w0;
            end else if (widx == 1) begin
                in_data = v.w1;
                if (v.gap == 0) in_valid = 1'b1;
                else in_valid = (o[5] && !o[4] && load_seen >= v.gap);
                if (o[5] && !o[4]) load_seen++;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && o[5]) widx++;
            @(negedge clk);
        end
        set_start(v.sel, 1'b0);
        in_valid = 1'b0;

        o = outs(v.sel);
        chk($sformatf("row%0d stream", r), stream, v.exp_stream);
        chk($sformatf("row%0d cen_count", r), 64'(cen_cnt), 64'(v.len));
        chk($sformatf("row%0d cen_bubble", r), 64'(bubble), 64'(v.exp_bubble));
        chk($sformatf("row%0d set_count", r), 64'(set_cnt), 64'd1);
        chk($sformatf("row%0d set_after_last_cen", r), 64'(set_cyc - last_cen), 64'd1);
        chk($sformatf("row%0d set_cen_overlap", r), 64'(overlap), 64'd0);
        chk($sformatf("row%0d done_after_set", r), 64'(done_cyc - set_cyc), 64'd1);
        chk($sformatf("row%0d final_outs", r), 64'(o), 64'b000001);
    endtask

    // 40-bit chain sits in DONE; in_valid there must not be taken.
    task automatic done_hold_test();
        logic [5:0] o;
        int rdy_cnt = 0;
        int done_cnt = 0;
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            o = outs(1'b0);
            if (o[5] || o[4]) rdy_cnt++;
            if (o[0]) done_cnt++;
        end
        in_valid = 1'b0;
        chk("done_hold_ready", 64'(rdy_cnt), 64'd0);
        chk("done_hold_done", 64'(done_cnt), 64'd6);
    endtask

    // Reset after 17 shifted bits aborts the load without a commit pulse.
    task automatic mid_reset_test();
        int n = 0;
        int stray = 0;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start  = 1'b0;
        in_data  = 32'hFFFFFFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && n < 17; i++) begin
            @(negedge clk);
            if (a_cen) n++;
        end
        chk("mid_reset_reached_17", 64'(n), 64'd17);
        rst = 1'b1;
        #1;
        chk("mid_reset_async_outs", 64'(outs(1'b0)), 64'd0);
        @(negedge clk);
        chk("mid_reset_held_outs", 64'(outs(1'b0)), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (outs(1'b0) != 6'd0) stray++;
        end
        in_valid = 1'b0;
        chk("mid_reset_idle_quiet", 64'(stray), 64'd0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 40, 32'hA5A5A5A5, 32'hFF000000, 0, 1'b0, 64'h000000A5A5A5A5FF, 0};
        tbl[1] = '{1'b0, 40, 32'hA5A5A5A5, 32'hFF000000, 5, 1'b0, 64'h000000A5A5A5A5FF, 6};
        tbl[2] = '{1'b0, 40, 32'h12345678, 32'h9ABCDEF0, 0, 1'b1, 64'h000000123456789A, 0};
        tbl[3] = '{1'b0, 40, 32'h0F0F0F0F, 32'h3C55AA11, 2, 1'b0, 64'h0000000F0F0F0F3C, 3};
        tbl[4] = '{1'b1, 64, 32'h80000001, 32'h80000001, 0, 1'b0, 64'h8000000180000001, 0};
        tbl[5] = '{1'b1, 64, 32'hDEADBEEF, 32'h01234567, 1, 1'b0, 64'hDEADBEEF01234567, 2};

        repeat (2) @(negedge clk);
        chk("reset_outs_a", 64'(outs(1'b0)), 64'd0);
        chk("reset_outs_b", 64'(outs(1'b1)), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs_a", 64'(outs(1'b0)), 64'd0);
        chk("idle_outs_b", 64'(outs(1'b1)), 64'd0);

        for (int r = 0; r < 6; r++) begin
            run_load(r);
            if (r == 0) done_hold_test();
            if (r == 2) mid_reset_test();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
